// File: rtl/soc2_sysid_pkg.sv
// Shared word offsets, CTRL bit positions and build defaults for the soc2 system-ID block.
package soc2_sysid_pkg;

    localparam logic [7:0] ADDR_ID         = 8'd0;
    localparam logic [7:0] ADDR_TIMESTAMP  = 8'd1;
    localparam logic [7:0] ADDR_HW_VERSION = 8'd2;
    localparam logic [7:0] ADDR_SCRATCH    = 8'd3;
    localparam logic [7:0] ADDR_UPTIME_LO  = 8'd4;
    localparam logic [7:0] ADDR_UPTIME_HI  = 8'd5;
    localparam logic [7:0] ADDR_CTRL       = 8'd6;

    localparam int unsigned CTRL_RUN_BIT   = 0;
    localparam int unsigned CTRL_CLEAR_BIT = 1;

    localparam logic [31:0] HW_VERSION_DEFAULT = 32'h0001_0000;

    // clear is write-1 self-clearing, so it always reads back as 0
    function automatic logic [31:0] ctrl_word(input logic run);
        logic [31:0] w;
        w = '0;
        w[CTRL_RUN_BIT] = run;
        return w;
    endfunction

endpackage

// File: rtl/soc2_sysid_uptime.sv
// 64-bit uptime counter with high-word snapshot and run/clear control.
module soc2_sysid_uptime
    import soc2_sysid_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        snap_req,
    input  logic        ctrl_we,
    input  logic        run_wdata,
    input  logic        clear_wdata,
    output logic [63:0] count,
    output logic [31:0] snapshot,
    output logic        run
);

    logic clear;

    assign clear = ctrl_we && clear_wdata;

    // clear wins over both increment and snapshot capture in the same cycle
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count    <= '0;
            snapshot <= '0;
            run      <= 1'b1;
        end else begin
            if (ctrl_we)
                run <= run_wdata;
            if (clear)
                count <= '0;
            else if (run)
                count <= count + 64'd1;
            if (clear)
                snapshot <= '0;
            else if (snap_req)
                snapshot <= count[63:32];
        end
    end

endmodule

// File: rtl/soc2_sysid_ext.sv
// Avalon-MM system-ID slave with scratch register; optional uptime counter
// enabled by defining SOC2_SYSID_UPTIME_EN.
module soc2_sysid_ext
    import soc2_sysid_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID  = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP  = 32'h6723_A0A6,
    parameter logic [31:0] HW_VERSION = HW_VERSION_DEFAULT,
    parameter int unsigned ADDR_W     = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

    logic [7:0]  word;
    logic [31:0] scratch;
    logic [31:0] rd_mux;

    assign word = 8'(address);

`ifdef SOC2_SYSID_UPTIME_EN
    logic [63:0] count;
    logic [31:0] snapshot;
    logic        run;

    soc2_sysid_uptime u_uptime (
        .clock       (clock),
        .reset_n     (reset_n),
        .snap_req    (read && (word == ADDR_UPTIME_LO)),
        .ctrl_we     (write && (word == ADDR_CTRL)),
        .run_wdata   (writedata[CTRL_RUN_BIT]),
        .clear_wdata (writedata[CTRL_CLEAR_BIT]),
        .count       (count),
        .snapshot    (snapshot),
        .run         (run)
    );
`endif

    always_comb begin
        rd_mux = '0;
        case (word)
            ADDR_ID:         rd_mux = SYSTEM_ID;
            ADDR_TIMESTAMP:  rd_mux = TIMESTAMP;
            ADDR_HW_VERSION: rd_mux = HW_VERSION;
            ADDR_SCRATCH:    rd_mux = scratch;
`ifdef SOC2_SYSID_UPTIME_EN
            ADDR_UPTIME_LO:  rd_mux = count[31:0];
            ADDR_UPTIME_HI:  rd_mux = snapshot;
            ADDR_CTRL:       rd_mux = ctrl_word(run);
`endif
            default:         rd_mux = '0;
        endcase
    end

    // read mux samples pre-edge state, so a same-word write is not visible yet
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
            scratch       <= '0;
        end else begin
            readdatavalid <= read;
            if (read)
                readdata <= rd_mux;
            if (write && (word == ADDR_SCRATCH))
                scratch <= writedata;
        end
    end

endmodule

// File: tb/tb_soc2_sysid_ext.sv
// Directed-vector bench for soc2_sysid_ext; uptime checks run when SOC2_SYSID_UPTIME_EN is defined.
module tb_soc2_sysid_ext;

    localparam logic [31:0] SYS_ID = 32'h50C2_0001;
    localparam logic [31:0] TS     = 32'h6723_A0A6;
    localparam logic [31:0] HWV    = 32'h0001_0000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        readdatavalid;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    soc2_sysid_ext #(
        .SYSTEM_ID (SYS_ID),
        .ADDR_W    (3)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // called at a falling edge; returns at the next falling edge
    task automatic read_word(input string tag, input logic [2:0] a, output logic [31:0] d);
        read = 1'b1;
        address = a;
        @(negedge clock);
        read = 1'b0;
        check({tag, ".valid"}, 64'(readdatavalid), 64'd1);
        d = readdata;
    endtask

    task automatic write_word(input logic [2:0] a, input logic [31:0] d);
        write = 1'b1;
        address = a;
        writedata = d;
        @(negedge clock);
        write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] d2;

        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check("rst.valid", 64'(readdatavalid), 64'd0);
        check("rst.rdata", 64'(readdata), 64'd0);
        reset_n = 1'b1;

        // back-to-back reads of the ID words
        read = 1'b1;
        address = 3'd0;
        @(negedge clock);
        check("b2b0.valid", 64'(readdatavalid), 64'd1);
        check("b2b0.data", 64'(readdata), 64'(SYS_ID));
        address = 3'd1;
        @(negedge clock);
        check("b2b1.valid", 64'(readdatavalid), 64'd1);
        check("b2b1.data", 64'(readdata), 64'(TS));
        address = 3'd2;
        @(negedge clock);
        check("b2b2.valid", 64'(readdatavalid), 64'd1);
        check("b2b2.data", 64'(readdata), 64'(HWV));
        read = 1'b0;
        @(negedge clock);
        check("idle.valid", 64'(readdatavalid), 64'd0);
        check("idle.hold", 64'(readdata), 64'(HWV));

        write_word(3'd3, 32'hDEAD_BEEF);
        read_word("scratch", 3'd3, d);
        check("scratch.data", 64'(d), 64'hDEAD_BEEF);

        write_word(3'd0, 32'h0000_1234);
        read_word("id_ro", 3'd0, d);
        check("id_ro.data", 64'(d), 64'(SYS_ID));
        write_word(3'd1, 32'hFFFF_FFFF);
        read_word("ts_ro", 3'd1, d);
        check("ts_ro.data", 64'(d), 64'(TS));

        write_word(3'd7, 32'hFFFF_FFFF);
        read_word("rsvd7", 3'd7, d);
        check("rsvd7.data", 64'(d), 64'd0);

        // same-cycle read and write of SCRATCH returns the old value
        read = 1'b1;
        write = 1'b1;
        address = 3'd3;
        writedata = 32'hA5A5_5A5A;
        @(negedge clock);
        read = 1'b0;
        write = 1'b0;
        check("rw.valid", 64'(readdatavalid), 64'd1);
        check("rw.old", 64'(readdata), 64'hDEAD_BEEF);
        read_word("rw_new", 3'd3, d);
        check("rw_new.data", 64'(d), 64'hA5A5_5A5A);

`ifdef SOC2_SYSID_UPTIME_EN
        // coherent pair across a low-word carry
        force dut.u_uptime.count = 64'h0000_0000_FFFF_FFFE;
        read = 1'b1;
        address = 3'd4;
        @(negedge clock);
        read = 1'b0;
        release dut.u_uptime.count;
        check("carry.lo_valid", 64'(readdatavalid), 64'd1);
        check("carry.lo", 64'(readdata), 64'hFFFF_FFFE);
        repeat (3) @(negedge clock);
        read_word("carry_hi", 3'd5, d);
        check("carry_hi.snap", 64'(d), 64'd0);
        read_word("carry_lo2", 3'd4, d);
        read_word("carry_hi2", 3'd5, d);
        check("carry_hi2.snap", 64'(d), 64'd1);

        // stopped counter holds its value
        write_word(3'd6, 32'h0000_0000);
        read_word("stop_lo1", 3'd4, d);
        repeat (10) @(negedge clock);
        read_word("stop_lo2", 3'd4, d2);
        check("stop.equal", 64'(d2), 64'(d));
        read_word("stop_ctrl", 3'd6, d);
        check("stop_ctrl.data", 64'(d), 64'd0);

        // clear with run: zero on the next cycle, then counts
        write_word(3'd6, 32'h0000_0003);
        read_word("clr_lo0", 3'd4, d);
        check("clr_lo0.data", 64'(d), 64'd0);
        read_word("clr_lo1", 3'd4, d);
        check("clr_lo1.data", 64'(d), 64'd1);
        read_word("clr_hi", 3'd5, d);
        check("clr_hi.data", 64'(d), 64'd0);
        read_word("clr_ctrl", 3'd6, d);
        check("clr_ctrl.data", 64'(d), 64'd1);
`else
        read_word("rsvd4", 3'd4, d);
        check("rsvd4.data", 64'(d), 64'd0);
        read_word("rsvd5", 3'd5, d);
        check("rsvd5.data", 64'(d), 64'd0);
        write_word(3'd6, 32'h0000_0002);
        write_word(3'd4, 32'hFFFF_FFFF);
        read_word("rsvd6", 3'd6, d);
        check("rsvd6.data", 64'(d), 64'd0);
        read_word("rsvd4b", 3'd4, d);
        check("rsvd4b.data", 64'(d), 64'd0);
        read_word("scr_keep", 3'd3, d);
        check("scr_keep.data", 64'(d), 64'hA5A5_5A5A);
`endif

        // reset sampled together with a read cancels that read
        read_word("pre_rst", 3'd2, d);
        check("pre_rst.data", 64'(d), 64'(HWV));
        read = 1'b1;
        address = 3'd3;
        reset_n = 1'b0;
        @(negedge clock);
        read = 1'b0;
        check("rstrd.valid0", 64'(readdatavalid), 64'd0);
        @(negedge clock);
        check("rstrd.valid1", 64'(readdatavalid), 64'd0);
        check("rstrd.rdata", 64'(readdata), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check("rstrd.valid2", 64'(readdatavalid), 64'd0);
        read_word("rst_scr", 3'd3, d);
        check("rst_scr.data", 64'(d), 64'd0);
`ifdef SOC2_SYSID_UPTIME_EN
        read_word("rst_hi", 3'd5, d);
        check("rst_hi.data", 64'(d), 64'd0);
        read_word("rst_ctrl", 3'd6, d);
        check("rst_ctrl.data", 64'(d), 64'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/soc2_sysid_ext.md
SOC2_SYSID_EXT -- requirements
Module: soc2_sysid_ext

Interface
REQ-001 Parameter SYSTEM_ID, default 32'h0000_0000, value returned at word 0.
REQ-002 Parameter TIMESTAMP, default 32'h6723_A0A6, build timestamp returned at word 1.
REQ-003 Parameter HW_VERSION, default 32'h0001_0000, version word returned at word 2.
REQ-004 Parameter ADDR_W, default 3, word-address width; legal 3..8.
REQ-005 clock  input  1  single clock; all state on rising edge.
REQ-006 reset_n  input  1  reset, synchronous, active-low.
REQ-007 address  input  ADDR_W  Avalon-MM word address.
REQ-008 read  input  1  read strobe.
REQ-009 write  input  1  write strobe.
REQ-010 writedata  input  32  write data.
REQ-011 readdata  output  32  read data, registered.
REQ-012 readdatavalid  output  1  one-cycle qualifier for readdata.

Function
REQ-013 Register map: 0 SYSTEM_ID (RO), 1 TIMESTAMP (RO), 2 HW_VERSION (RO), 3 SCRATCH (RW), 4 UPTIME_LO (RO), 5 UPTIME_HI (RO, snapshot), 6 CTRL (RW), 7+ reserved (read 0, writes ignored).
REQ-014 Fixed read latency of 1: read at cycle N -> readdata and readdatavalid=1 at N+1; readdatavalid=0 otherwise; no waitrequest, back-to-back reads every cycle.
REQ-015 readdata holds its last value when readdatavalid=0.
REQ-016 Writes take effect at the next edge; writes to RO words have no effect.
REQ-017 Simultaneous read and write to the same word: read returns the pre-write value.
REQ-018 UPTIME: 64-bit free-running counter, +1 per clock while CTRL.run=1, wraps 2^64-1 -> 0 silently.
REQ-019 Reading UPTIME_LO returns the live low word and latches the live high word into the 32-bit HI snapshot in the same cycle; UPTIME_HI returns the snapshot, giving a coherent 64-bit pair across a carry.
REQ-020 CTRL bit0 run (reset 1); bit1 clear, write-1 self-clearing: zeroes counter and snapshot at the next edge, clear beats increment in that cycle; bits 31:2 read 0.
REQ-021 CTRL read returns run in bit0, 0 in bit1.

Reset
REQ-022 While reset_n=0 at an edge: readdata=0, readdatavalid=0, SCRATCH=0, counter=0, snapshot=0, run=1.
REQ-023 Reset asserted with a read in flight cancels it: no readdatavalid pulse after reset release for that read.

Configuration
REQ-024 Macro SOC2_SYSID_UPTIME_EN defined: UPTIME_LO, UPTIME_HI and CTRL implemented per REQ-018..021.
REQ-025 Macro absent: no counter or snapshot flops; words 4..6 behave as reserved (read 0, writes ignored); all other behaviour unchanged.

Structure
REQ-026 Package soc2_sysid_pkg holds the word-offset constants (ADDR_ID..ADDR_CTRL), CTRL bit indices and the default HW_VERSION.
REQ-027 One sub-module, soc2_sysid_uptime (counter, snapshot, run/clear), instantiated only under SOC2_SYSID_UPTIME_EN.

Verification
REQ-028 Reset release, read words 0,1,2 back-to-back -> SYSTEM_ID, TIMESTAMP, HW_VERSION on three consecutive cycles, each with readdatavalid=1, latency 1.
REQ-029 Write SCRATCH=32'hDEAD_BEEF, read 3 -> 32'hDEAD_BEEF; write word 0 = 32'h1234, read 0 -> SYSTEM_ID unchanged; read word 7 -> 0.
REQ-030 Force counter to 64'h0000_0000_FFFF_FFFE, read LO, wait 4 cycles, read HI -> pair reads LO=32'hFFFF_FFFE, HI=0 (snapshot, not live HI=1).
REQ-031 Write CTRL=0 (run=0), read LO twice 10 cycles apart -> equal; write CTRL=3 -> counter 0 next cycle, then increments; CTRL reads 1.
REQ-032 Read issued, reset_n=0 the next cycle for 2 cycles -> readdatavalid never 1, all registers at reset values.
REQ-033 Build without SOC2_SYSID_UPTIME_EN: read words 4,5,6 -> 0; write CTRL=2 -> no effect; REQ-028/029 still pass.
